// File: rtl/mips_defs_pkg.sv
`default_nettype none
// ============================================================================
// mips_defs_pkg : shared opcode, ALU command and branch-type encodings
// Rev 1.0
// ============================================================================
package mips_defs_pkg;

   localparam logic [5:0] c_OP_ADD  = 6'b000001;
   localparam logic [5:0] c_OP_SUB  = 6'b000011;
   localparam logic [5:0] c_OP_AND  = 6'b000101;
   localparam logic [5:0] c_OP_OR   = 6'b000110;
   localparam logic [5:0] c_OP_NOR  = 6'b000111;
   localparam logic [5:0] c_OP_XOR  = 6'b001000;
   localparam logic [5:0] c_OP_SLA  = 6'b001001;
   localparam logic [5:0] c_OP_SLL  = 6'b001010;
   localparam logic [5:0] c_OP_SRA  = 6'b001011;
   localparam logic [5:0] c_OP_SRL  = 6'b001100;
   localparam logic [5:0] c_OP_ADDI = 6'b100000;
   localparam logic [5:0] c_OP_SUBI = 6'b100001;
   localparam logic [5:0] c_OP_LD   = 6'b100100;
   localparam logic [5:0] c_OP_ST   = 6'b100101;
   localparam logic [5:0] c_OP_BEQ  = 6'b101000;
   localparam logic [5:0] c_OP_BNE  = 6'b101001;
   localparam logic [5:0] c_OP_JMP  = 6'b101010;

   localparam logic [3:0] c_ALU_ADD = 4'b0000;
   localparam logic [3:0] c_ALU_SUB = 4'b0010;
   localparam logic [3:0] c_ALU_AND = 4'b0100;
   localparam logic [3:0] c_ALU_OR  = 4'b0101;
   localparam logic [3:0] c_ALU_NOR = 4'b0110;
   localparam logic [3:0] c_ALU_XOR = 4'b0111;
   localparam logic [3:0] c_ALU_SHL = 4'b1000;
   localparam logic [3:0] c_ALU_SRA = 4'b1001;
   localparam logic [3:0] c_ALU_SRL = 4'b1010;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_BEQ  = 2'b01,
      BR_BNE  = 2'b10,
      BR_JMP  = 2'b11
   } br_type_e;

endpackage
`default_nettype wire

// File: rtl/op_decoder.sv
`default_nettype none
// ============================================================================
// op_decoder : purely combinational opcode-to-control decode
// Rev 1.0
// ============================================================================
module op_decoder
   import mips_defs_pkg::*;
#(
   parameter int OPCODE_W  = 6,
   parameter int ALU_CMD_W = 4
) (
   input  logic [OPCODE_W-1:0]  i_opcode,
   output logic                 o_legal,
   output logic                 o_is_imm,
   output logic                 o_wb_en,
   output logic                 o_mem_r,
   output logic                 o_mem_w,
   output logic [ALU_CMD_W-1:0] o_alu_cmd,
   output logic [1:0]           o_br_type,
   output logic                 o_use_src1,
   output logic                 o_use_src2
);

   always_comb begin
      o_legal    = 1'b1;
      o_is_imm   = 1'b0;
      o_wb_en    = 1'b0;
      o_mem_r    = 1'b0;
      o_mem_w    = 1'b0;
      o_alu_cmd  = '0;
      o_br_type  = BR_NONE;
      o_use_src1 = 1'b1;
      o_use_src2 = 1'b0;
      case (i_opcode)
         OPCODE_W'(c_OP_ADD): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_ADD); end
         OPCODE_W'(c_OP_SUB): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_SUB); end
         OPCODE_W'(c_OP_AND): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_AND); end
         OPCODE_W'(c_OP_OR):  begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_OR);  end
         OPCODE_W'(c_OP_NOR): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_NOR); end
         OPCODE_W'(c_OP_XOR): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_XOR); end
         OPCODE_W'(c_OP_SLA),
         OPCODE_W'(c_OP_SLL): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_SHL); end
         OPCODE_W'(c_OP_SRA): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_SRA); end
         OPCODE_W'(c_OP_SRL): begin o_wb_en = 1'b1; o_use_src2 = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_SRL); end
         OPCODE_W'(c_OP_ADDI): begin o_wb_en = 1'b1; o_is_imm = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_ADD); end
         OPCODE_W'(c_OP_SUBI): begin o_wb_en = 1'b1; o_is_imm = 1'b1; o_alu_cmd = ALU_CMD_W'(c_ALU_SUB); end
         OPCODE_W'(c_OP_LD): begin
            o_wb_en  = 1'b1;
            o_is_imm = 1'b1;
            o_mem_r  = 1'b1;
         end
         // A store reads src2 as its data operand even though it is immediate-addressed.
         OPCODE_W'(c_OP_ST): begin
            o_is_imm   = 1'b1;
            o_mem_w    = 1'b1;
            o_use_src2 = 1'b1;
         end
         OPCODE_W'(c_OP_BEQ): begin o_br_type = BR_BEQ; o_use_src2 = 1'b1; end
         OPCODE_W'(c_OP_BNE): begin o_br_type = BR_BNE; o_use_src2 = 1'b1; end
         OPCODE_W'(c_OP_JMP): begin o_br_type = BR_JMP; o_use_src1 = 1'b0; end
         default: o_legal = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// id_ctrl_pipe : ID-stage decode, load-use hazard detection and ID/EX register
// Rev 1.0
// ============================================================================
module id_ctrl_pipe
   import mips_defs_pkg::*;
#(
   parameter int OPCODE_W  = 6,
   parameter int ALU_CMD_W = 4,
   parameter int REG_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [OPCODE_W-1:0]  opcode,
   input  logic [REG_W-1:0]     src1,
   input  logic [REG_W-1:0]     src2,
   input  logic [REG_W-1:0]     dest,
   input  logic                 freeze,
   input  logic                 flush,
   output logic                 hazard_stall,
   output logic                 ex_valid,
   output logic                 ex_is_imm,
   output logic                 ex_wb_en,
   output logic                 ex_mem_r,
   output logic                 ex_mem_w,
   output logic [ALU_CMD_W-1:0] ex_alu_cmd,
   output logic [1:0]           ex_br_type,
   output logic [REG_W-1:0]     ex_dest,
   output logic                 illegal_op
);

   logic                 w_legal, w_is_imm, w_wb_en, w_mem_r, w_mem_w;
   logic [ALU_CMD_W-1:0] w_alu_cmd;
   logic [1:0]           w_br_type;
   logic                 w_use_src1, w_use_src2;
   logic                 w_hazard, w_bubble;

   logic                 r_valid, r_is_imm, r_wb_en, r_mem_r, r_mem_w, r_illegal;
   logic [ALU_CMD_W-1:0] r_alu_cmd;
   logic [1:0]           r_br_type;
   logic [REG_W-1:0]     r_dest;

   op_decoder #(
      .OPCODE_W  (OPCODE_W),
      .ALU_CMD_W (ALU_CMD_W)
   ) u_dec (
      .i_opcode   (opcode),
      .o_legal    (w_legal),
      .o_is_imm   (w_is_imm),
      .o_wb_en    (w_wb_en),
      .o_mem_r    (w_mem_r),
      .o_mem_w    (w_mem_w),
      .o_alu_cmd  (w_alu_cmd),
      .o_br_type  (w_br_type),
      .o_use_src1 (w_use_src1),
      .o_use_src2 (w_use_src2)
   );

   assign w_hazard = in_valid & r_valid & r_mem_r & (r_dest != '0) & ~flush &
                     ((w_use_src1 & (src1 == r_dest)) | (w_use_src2 & (src2 == r_dest)));

   // Flush outranks freeze, so the register advances on flush even while frozen.
   assign w_bubble = flush | w_hazard | ~in_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_is_imm  <= 1'b0;
         r_wb_en   <= 1'b0;
         r_mem_r   <= 1'b0;
         r_mem_w   <= 1'b0;
         r_alu_cmd <= '0;
         r_br_type <= 2'b00;
         r_dest    <= '0;
         r_illegal <= 1'b0;
      end else if (flush | ~freeze) begin
         r_valid   <= ~w_bubble;
         r_is_imm  <= ~w_bubble & w_is_imm;
         r_wb_en   <= ~w_bubble & w_wb_en & (dest != '0);
         r_mem_r   <= ~w_bubble & w_mem_r;
         r_mem_w   <= ~w_bubble & w_mem_w;
         r_alu_cmd <= w_bubble ? '0 : w_alu_cmd;
         r_br_type <= w_bubble ? 2'b00 : w_br_type;
         r_dest    <= (w_bubble | ~w_legal) ? '0 : dest;
         r_illegal <= ~w_bubble & ~w_legal;
      end
   end

   assign hazard_stall = w_hazard;
   assign ex_valid     = r_valid;
   assign ex_is_imm    = r_is_imm;
   assign ex_wb_en     = r_wb_en;
   assign ex_mem_r     = r_mem_r;
   assign ex_mem_w     = r_mem_w;
   assign ex_alu_cmd   = r_alu_cmd;
   assign ex_br_type   = r_br_type;
   assign ex_dest      = r_dest;
   assign illegal_op   = r_illegal;

endmodule
`default_nettype wire

// File: doc/id_ctrl_pipe.md
ID_CTRL_PIPE -- requirements
Module: id_ctrl_pipe

Interface
REQ-001 Parameters SHALL be: OPCODE_W, default 6, opcode width; ALU_CMD_W, default 4, ALU command width (minimum 4); REG_W, default 5, register-address width.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  ID-stage instruction present.
REQ-005 opcode  input  OPCODE_W  ID-stage opcode.
REQ-006 src1, src2, dest  input  REG_W each  ID-stage register addresses.
REQ-007 freeze  input  1  hold the ID/EX register (memory stall).
REQ-008 flush  input  1  squash the ID-stage instruction (branch taken).
REQ-009 hazard_stall  output  1  combinational; stall IF/ID this cycle.
REQ-010 ex_valid, ex_is_imm, ex_wb_en, ex_mem_r, ex_mem_w  output  1 each  registered EX-stage controls.
REQ-011 ex_alu_cmd  output  ALU_CMD_W  registered ALU command.
REQ-012 ex_br_type  output  2  registered branch type: 00 none, 01 BEQ, 10 BNE, 11 JMP.
REQ-013 ex_dest  output  REG_W  registered destination register.
REQ-014 illegal_op  output  1  registered; high for one cycle after an undecodable valid opcode is accepted.

Function
REQ-015 Opcodes SHALL be binary constants: ADD 000001, SUB 000011, AND 000101, OR 000110, NOR 000111, XOR 001000, SLA 001001, SLL 001010, SRA 001011, SRL 001100, ADDI 100000, SUBI 100001, LD 100100, ST 100101, BEQ 101000, BNE 101001, JMP 101010, zero-extended to OPCODE_W.
REQ-016 ALU commands SHALL be: ADD/ADDI/LD/ST 0000, SUB/SUBI 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLA/SLL 1000, SRA 1001, SRL 1010, zero-extended to ALU_CMD_W; branches and JMP SHALL use 0000.
REQ-017 is_imm SHALL be 1 for ADDI, SUBI, LD, ST; 0 otherwise.
REQ-018 wb_en SHALL be 1 for R-type, ADDI, SUBI, LD, and forced to 0 when dest == 0; mem_r SHALL be 1 only for LD; mem_w SHALL be 1 only for ST.
REQ-019 An undecodable opcode SHALL decode to all-zero controls and set illegal_op; ex_valid SHALL still follow in_valid for it.
REQ-020 src1 SHALL count as used for every opcode except JMP; src2 SHALL count as used for R-type, ST, BEQ, BNE.
REQ-021 hazard_stall SHALL be 1 iff in_valid & ex_valid & ex_mem_r & ex_dest != 0 & ex_dest matches a used source, and flush == 0.
REQ-022 Each cycle the ID/EX register SHALL update with priority rst > flush > freeze > hazard > load.
REQ-023 Flush SHALL load a bubble: ex_valid and all enables 0, ex_alu_cmd 0, ex_br_type 00, ex_dest 0, illegal_op 0.
REQ-024 Freeze SHALL hold every registered output including illegal_op; hazard_stall SHALL still be computed during freeze.
REQ-025 Hazard (no flush, no freeze) SHALL load a bubble; the stalled instruction SHALL load on the following cycle, giving exactly one bubble per load-use.
REQ-026 Load with in_valid == 0 SHALL load a bubble.
REQ-027 Decode-to-ex_* latency SHALL be exactly one cycle.

Reset
REQ-028 With rst high at a rising edge, every registered output SHALL become 0 on that edge; hazard_stall SHALL be 0 while ex_valid is 0.
REQ-029 Reset asserted mid-stall SHALL discard the pending instruction; no bubble SHALL follow reset release.

Structure
REQ-030 Opcode constants, ALU command constants and branch-type encodings SHALL reside in a shared package mips_defs_pkg, reused by the ALU and branch unit.
REQ-031 Pure decoding SHALL be a combinational sub-module op_decoder; id_ctrl_pipe SHALL hold the hazard logic and the ID/EX register.

Verification
REQ-032 ADD dest=3 then SUB, in_valid=1 -> ex_alu_cmd 0000 then 0010, ex_wb_en=1, each one cycle after input.
REQ-033 LD dest=4, next ADD src1=4 -> hazard_stall=1 for one cycle, one bubble (ex_valid=0), ADD in EX the next cycle.
REQ-034 LD dest=0, next ADD src1=0 -> hazard_stall=0, ex_wb_en=0 for the LD.
REQ-035 LD dest=4, next ADD src1=4 with flush=1 -> hazard_stall=0, bubble loaded, no further stall.
REQ-036 freeze=1 for 3 cycles holding ADDI -> ex_* unchanged, ex_is_imm=1 throughout.
REQ-037 opcode 111111 valid -> illegal_op=1 for one cycle, all enables 0; rst during a hazard stall -> all outputs 0 next cycle.
